// File: rtl/regfile_sb.sv
// Parametrised register file with same-cycle write bypass, byte-lane writes,
// a per-register outstanding-writer scoreboard and a post-reset clear sequencer.
module regfile_sb #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      DEPTH     = 32,
    parameter int unsigned      AW        = 5,
    parameter int unsigned      CNT_W     = 2,
    parameter int unsigned      ZERO_REG  = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               ready,
    input  logic [AW-1:0]      rreg1,
    input  logic [AW-1:0]      rreg2,
    output logic [WIDTH-1:0]   rdata1,
    output logic [WIDTH-1:0]   rdata2,
    output logic               rbusy1,
    output logic               rbusy2,
    input  logic [AW-1:0]      wreg,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               w_en,
    input  logic [WIDTH/8-1:0] w_be,
    input  logic [AW-1:0]      set_reg,
    input  logic               set_en,
    output logic               sb_err
);

    localparam int unsigned     NB      = WIDTH / 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    ptr_q;
    logic             ready_q, ready_d;
    logic             sb_err_q;
    logic             clear_en_c, run_c, ovf_c;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] cnt_q [DEPTH];
    logic [CNT_W-1:0] cnt_d [DEPTH];
    logic [DEPTH-1:0] w_hit_c, s_hit_c;

    // Address maps to a real, writable register (not out of range, not the zero register).
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [WIDTH-1:0] rd_data(input logic [AW-1:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        if (addr_ok(a)) begin
            if (!run_c) begin
                v = RESET_VAL;
            end else begin
                v = mem_q[a];
                if (w_en && (wreg == a)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (w_be[b]) v[8*b +: 8] = wdata[8*b +: 8];
                    end
                end
            end
        end
        return v;
    endfunction

    // Busy unless the same-cycle write retires the last outstanding writer.
    function automatic logic rd_busy(input logic [AW-1:0] a);
        logic [CNT_W-1:0] c;
        logic             busy;
        busy = 1'b0;
        if (addr_ok(a) && run_c) begin
            c    = cnt_q[a];
            busy = (c != '0) &&
                   !(w_en && (wreg == a) && (c == CNT_ONE) && !(set_en && (set_reg == a)));
        end
        return busy;
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if ((state_q == ST_CLEAR) && (ptr_q == AW'(DEPTH - 1))) state_d = ST_RUN;
    end

    // FSM outputs
    always_comb begin
        clear_en_c = 1'b0;
        run_c      = 1'b0;
        ready_d    = (state_d == ST_RUN);
        if (state_q == ST_CLEAR) clear_en_c = 1'b1;
        else                     run_c      = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)             ptr_q <= '0;
        else if (clear_en_c) ptr_q <= ptr_q + AW'(1);
    end

    always_comb begin
        w_hit_c = '0;
        s_hit_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_hit_c[i] = run_c && w_en   && (wreg    == AW'(i)) && addr_ok(wreg);
            s_hit_c[i] = run_c && set_en && (set_reg == AW'(i)) && addr_ok(set_reg);
        end
    end

    // Scoreboard next state; a set on a saturated counter is dropped and flagged.
    always_comb begin
        ovf_c = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s_hit_c[i] && !w_hit_c[i]) begin
                if (cnt_q[i] == CNT_MAX) ovf_c    = 1'b1;
                else                     cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (w_hit_c[i] && !s_hit_c[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
            sb_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= cnt_d[i];
            sb_err_q <= ovf_c;
        end
    end

    // Storage: cleared by the sequencer, then byte-lane writes in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clear_en_c && (ptr_q == AW'(i))) begin
                    mem_q[i] <= RESET_VAL;
                end else if (w_hit_c[i]) begin
                    for (int b = 0; b < NB; b++) begin
                        if (w_be[b]) mem_q[i][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rdata1 = rd_data(rreg1);
        rdata2 = rd_data(rreg2);
        rbusy1 = rd_busy(rreg1);
        rbusy2 = rd_busy(rreg2);
    end

    assign ready  = ready_q;
    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: clear sequencing, byte writes with bypass,
// scoreboard counting/overflow, zero register and reset during clear.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [4:0]  rreg1, rreg2, wreg, set_reg;
    logic [31:0] rdata1, rdata2, wdata;
    logic        rbusy1, rbusy2, w_en, set_en, sb_err;
    logic [3:0]  w_be;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_sb dut (
        .clk(clk), .rst(rst), .ready(ready),
        .rreg1(rreg1), .rreg2(rreg2), .rdata1(rdata1), .rdata2(rdata2),
        .rbusy1(rbusy1), .rbusy2(rbusy2),
        .wreg(wreg), .wdata(wdata), .w_en(w_en), .w_be(w_be),
        .set_reg(set_reg), .set_en(set_en), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Advance one edge; inputs change 1ns after it, outputs settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_write(input logic [4:0] r, input logic [3:0] be, input logic [31:0] d);
        w_en = 1'b1; wreg = r; w_be = be; wdata = d;
        tick();
        w_en = 1'b0;
    endtask

    task automatic do_set(input logic [4:0] r);
        set_en = 1'b1; set_reg = r;
        tick();
        set_en = 1'b0;
    endtask

    // Release reset and check ready stays low for 32 cycles then rises.
    task automatic wait_clear(input string tag);
        int early;
        early = 0;
        rst = 1'b0;
        settle();
        check({tag, "_ready0"}, 32'(ready), 32'd0);
        for (int k = 1; k < 32; k++) begin
            tick();
            if (ready) early++;
        end
        check({tag, "_ready_early"}, 32'(early), 32'd0);
        tick();
        check({tag, "_ready1"}, 32'(ready), 32'd1);
    endtask

    task automatic read_all_zero(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            rreg1 = 5'(i); rreg2 = 5'(31 - i);
            settle();
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0) bad++;
        end
        check({tag, "_clear_reads_bad"}, 32'(bad), 32'd0);
    endtask

    initial begin
        rst = 1'b1; w_en = 1'b0; set_en = 1'b0; w_be = '0; wdata = '0;
        wreg = '0; set_reg = '0; rreg1 = '0; rreg2 = '0;
        tick();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_sb_err", 32'(sb_err), 32'd0);
        check("rst_rbusy", 32'(rbusy1), 32'd0);
        wait_clear("init");
        read_all_zero("init");

        // Byte write and bypass
        do_write(5'd5, 4'hF, 32'h11223344);
        w_en = 1'b1; wreg = 5'd5; w_be = 4'b0001; wdata = 32'hAABBCCDD; rreg1 = 5'd5;
        settle();
        check("byte_bypass", rdata1, 32'h112233DD);
        tick();
        w_en = 1'b0;
        settle();
        check("byte_stored", rdata1, 32'h112233DD);

        // Scoreboard: two sets, two writes
        rreg1 = 5'd7; set_en = 1'b1; set_reg = 5'd7;
        settle();
        check("set_same_cycle_busy", 32'(rbusy1), 32'd0);
        tick();
        set_en = 1'b0;
        do_set(5'd7);
        settle();
        check("busy_cnt2", 32'(rbusy1), 32'd1);
        w_en = 1'b1; wreg = 5'd7; w_be = 4'hF; wdata = 32'h0000_0007;
        settle();
        check("busy_w1_bypass", 32'(rbusy1), 32'd1);
        tick();
        w_en = 1'b0;
        settle();
        check("busy_cnt1", 32'(rbusy1), 32'd1);
        w_en = 1'b1; wreg = 5'd7; wdata = 32'h0000_0077;
        settle();
        check("busy_w2_bypass", 32'(rbusy1), 32'd0);
        check("data_w2_bypass", rdata1, 32'h0000_0077);
        tick();
        w_en = 1'b0;
        settle();
        check("busy_cnt0", 32'(rbusy1), 32'd0);

        // Overflow on reg 9
        rreg2 = 5'd9;
        do_set(5'd9); do_set(5'd9); do_set(5'd9);
        settle();
        check("ovf_err_before", 32'(sb_err), 32'd0);
        do_set(5'd9);
        settle();
        check("ovf_err_pulse", 32'(sb_err), 32'd1);
        tick();
        check("ovf_err_clear", 32'(sb_err), 32'd0);
        do_write(5'd9, 4'hF, 32'h1); do_write(5'd9, 4'hF, 32'h2);
        settle();
        check("ovf_busy_after2", 32'(rbusy2), 32'd1);
        do_write(5'd9, 4'hF, 32'h3);
        settle();
        check("ovf_busy_after3", 32'(rbusy2), 32'd0);

        // Set and retire on the same register in one cycle keeps the count
        rreg1 = 5'd3;
        do_set(5'd3);
        set_en = 1'b1; set_reg = 5'd3; w_en = 1'b1; wreg = 5'd3; w_be = 4'hF; wdata = 32'h33;
        settle();
        check("setwr_same_busy", 32'(rbusy1), 32'd1);
        tick();
        set_en = 1'b0; w_en = 1'b0;
        settle();
        check("setwr_after_busy", 32'(rbusy1), 32'd1);
        do_write(5'd3, 4'hF, 32'h34);
        settle();
        check("setwr_retired", 32'(rbusy1), 32'd0);

        // Empty byte mask still retires, data unchanged
        rreg1 = 5'd14;
        do_write(5'd14, 4'hF, 32'hCAFEF00D);
        do_set(5'd14);
        do_write(5'd14, 4'h0, 32'h0);
        settle();
        check("be0_retire", 32'(rbusy1), 32'd0);
        check("be0_data", rdata1, 32'hCAFEF00D);
        do_write(5'd14, 4'b1010, 32'h1122_3344);
        settle();
        check("be1010_data", rdata1, 32'h11FE330D);

        // Zero register
        rreg1 = 5'd0;
        w_en = 1'b1; wreg = 5'd0; w_be = 4'hF; wdata = 32'hFFFFFFFF;
        set_en = 1'b1; set_reg = 5'd0;
        settle();
        check("zero_bypass", rdata1, 32'h0);
        check("zero_busy_now", 32'(rbusy1), 32'd0);
        tick(); tick(); tick(); tick();
        w_en = 1'b0; set_en = 1'b0;
        settle();
        check("zero_data", rdata1, 32'h0);
        check("zero_busy", 32'(rbusy1), 32'd0);
        check("zero_sb_err", 32'(sb_err), 32'd0);

        // Reset in RUN with an outstanding writer, then reset mid-clear
        do_set(5'd20);
        rreg1 = 5'd20;
        settle();
        check("pre_rst_busy", 32'(rbusy1), 32'd1);
        rst = 1'b1;
        tick();
        check("run_rst_ready", 32'(ready), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1;
        tick();
        wait_clear("midclr");
        read_all_zero("midclr");
        rreg1 = 5'd20;
        settle();
        check("post_rst_busy", 32'(rbusy1), 32'd0);
        check("post_rst_sb_err", 32'(sb_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
